digit_entry: RTL and testbench
==============================

// Module: digit_entry
// PURPOSE
//  Entry-phase front end for the memorization game. Debounces the Enter and
//  Delete buttons and shifts 4-bit switch digits into a 16-bit guess. Asserts
//  inputReady once NUM_DIGITS digits are held. Drives userInput/inputReady into
//  checkInput and display, and is disabled while the display phase runs.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a button level is accepted (5 ms @ 100 MHz)
//  NUM_DIGITS       4       digits per guess; userInput width = 4*NUM_DIGITS
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   asynchronous, active-high reset
//  enable       in   1   entry phase active (driven as ~displayPhase)
//  sw           in   4   digit value, sampled on the accepted Enter press
//  btnEnter     in   1   raw Enter button, asynchronous, bouncy
//  btnDel       in   1   raw Delete button, asynchronous, bouncy
//  userInput    out  16  entered digits, most recent in [3:0]
//  inputReady   out  1   high while all NUM_DIGITS digits are held
//  digitCount   out  3   number of digits currently held, 0..NUM_DIGITS
//  digitStrobe  out  1   one-cycle pulse when a digit is added or removed
// BEHAVIOUR
//  Reset (async, immediate, no clock needed):
//   - userInput=0, inputReady=0, digitCount=0, digitStrobe=0, FSM=IDLE.
//   - Synchronizers, debounce counters and debounced levels are cleared to 0.
//  Button path, per button:
//   - Raw input passes through a 2-FF synchronizer.
//   - Counter resets when the synced level equals the debounced level; otherwise it increments.
//   - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
//   - A 0->1 debounced transition gives a one-cycle press pulse.
//   - Raw edge to pulse: 2 + DEBOUNCE_CYCLES cycles. Releases give no pulse.
//   - Button held through reset release: one press after the debounce time.
//  FSM (registered; outputs update on the edge after the press pulse):
//   - IDLE: all outputs held at reset values. enable=1 -> ENTER.
//   - ENTER:
//      - Enter press: userInput <= {userInput[11:0], sw}; digitCount++; digitStrobe=1.
//        If the new count == NUM_DIGITS -> DONE, inputReady=1 in the same cycle.
//      - Del press with count>0: userInput <= userInput>>4; digitCount--; digitStrobe=1.
//      - Del press with count==0: ignored, no strobe.
//   - DONE: inputReady=1 and userInput frozen.
//      - Enter press: ignored.
//      - Del press: shift right, count=NUM_DIGITS-1, inputReady=0, strobe, -> ENTER.
//  Simultaneous events:
//   - Enter and Del pulses in the same cycle: both ignored, no change, no strobe.
//   - enable=0 in any state overrides presses. Next edge: -> IDLE, userInput/count/ready cleared.
//   - Debouncers keep running while enable=0. Presses while enable=0 are dropped, not queued.
//  Width rules:
//   - digitCount never exceeds NUM_DIGITS and never wraps below 0.
//   - Shifts fill with zero.
// TESTING  (DEBOUNCE_CYCLES=4 in sim, clk period 10)
//  1. rst 130 ns, enable=1, Enter presses with sw=F,F,1,2
//     -> userInput=16'hFF12, digitCount=4, inputReady=1, exactly 4 strobes.
//  2. btnEnter toggles every 2 clk for 20 clk, then held high, sw=7
//     -> exactly one digit accepted, userInput=16'h0007.
//  3. Enter A,B then Del -> userInput=16'h000A, count=1.
//     Fill to FF12, then Del -> inputReady=0, userInput=16'h0FF1, count=3.
//  4. In DONE, Enter press with sw=3 -> userInput stays 16'hFF12, no strobe.
//     Same-cycle Enter+Del in ENTER -> no change.
//  5. enable 1->0 after 2 digits -> next edge all outputs 0.
//     Assert rst mid-edge-window -> outputs 0 before the next clk edge.
//  6. Del press at count=0 -> no strobe, digitCount stays 0, userInput stays 0.

Source files
------------

// File: rtl/digit_entry.sv
// Digit entry front end: debounced Enter/Delete buttons shift
// switch digits into a guess word and flag when it is complete.

module digit_entry_debounce #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          lvl;
    logic [CW-1:0] cnt;

    // Synchronize, then accept a new level only after it holds steady
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                lvl   <= s2;
                cnt   <= '0;
                press <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

module digit_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_DIGITS      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [3:0]              sw,
    input  logic                    btnEnter,
    input  logic                    btnDel,
    output logic [4*NUM_DIGITS-1:0] userInput,
    output logic                    inputReady,
    output logic [2:0]              digitCount,
    output logic                    digitStrobe
);

    localparam int W = 4 * NUM_DIGITS;
    localparam logic [2:0] FULL = 3'(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        DONE
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   ui_n;
    logic [2:0]     cnt_n;
    logic           rdy_n;
    logic           stb_n;
    logic           ent_p;
    logic           del_p;
    logic           ent;
    logic           del;

    digit_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ent (
        .clk   (clk),
        .rst   (rst),
        .btn   (btnEnter),
        .press (ent_p)
    );

    digit_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_del (
        .clk   (clk),
        .rst   (rst),
        .btn   (btnDel),
        .press (del_p)
    );

    // A coincident Enter and Delete cancel each other out
    assign ent = ent_p & ~del_p;
    assign del = del_p & ~ent_p;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            userInput   <= '0;
            digitCount  <= '0;
            inputReady  <= 1'b0;
            digitStrobe <= 1'b0;
        end else begin
            state       <= state_n;
            userInput   <= ui_n;
            digitCount  <= cnt_n;
            inputReady  <= rdy_n;
            digitStrobe <= stb_n;
        end
    end

    // Next state and next output values
    always_comb begin
        state_n = state;
        ui_n    = userInput;
        cnt_n   = digitCount;
        rdy_n   = inputReady;
        stb_n   = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            ui_n    = '0;
            cnt_n   = '0;
            rdy_n   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = ENTER;
                    ui_n    = '0;
                    cnt_n   = '0;
                    rdy_n   = 1'b0;
                end
                ENTER: begin
                    if (ent) begin
                        ui_n  = (userInput << 4) | W'(sw);
                        cnt_n = digitCount + 3'd1;
                        stb_n = 1'b1;
                        if (cnt_n == FULL) begin
                            state_n = DONE;
                            rdy_n   = 1'b1;
                        end
                    end else if (del && digitCount != 3'd0) begin
                        ui_n  = userInput >> 4;
                        cnt_n = digitCount - 3'd1;
                        stb_n = 1'b1;
                    end
                end
                DONE: begin
                    if (del) begin
                        ui_n    = userInput >> 4;
                        cnt_n   = FULL - 3'd1;
                        rdy_n   = 1'b0;
                        stb_n   = 1'b1;
                        state_n = ENTER;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_entry.sv
// Scoreboard bench for digit_entry: expected values queued per press,
// popped by a monitor on every digitStrobe.

module tb_digit_entry;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  sw;
    logic        btnEnter;
    logic        btnDel;
    logic [15:0] userInput;
    logic        inputReady;
    logic [2:0]  digitCount;
    logic        digitStrobe;

    typedef struct packed {
        logic [15:0] ui;
        logic [2:0]  cnt;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   fails;
    int   strobes;

    digit_entry #(
        .DEBOUNCE_CYCLES(4),
        .NUM_DIGITS     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sw         (sw),
        .btnEnter   (btnEnter),
        .btnDel     (btnDel),
        .userInput  (userInput),
        .inputReady (inputReady),
        .digitCount (digitCount),
        .digitStrobe(digitStrobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && digitStrobe) begin
            strobes++;
            if (q.size() == 0) begin
                check("unexpected_strobe", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("strobe_userInput", 32'(userInput), 32'(e.ui));
                check("strobe_digitCount", 32'(digitCount), 32'(e.cnt));
                check("strobe_inputReady", 32'(inputReady), 32'(e.rdy));
            end
        end
    end

    task automatic expect_strobe(input logic [15:0] ui,
                                 input logic [2:0] cnt, input logic rdy);
        exp_t e;
        e.ui  = ui;
        e.cnt = cnt;
        e.rdy = rdy;
        q.push_back(e);
    endtask

    task automatic press(input logic ent, input logic del);
        @(negedge clk);
        btnEnter = ent;
        btnDel   = del;
        repeat (10) @(negedge clk);
        btnEnter = 1'b0;
        btnDel   = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic digit(input logic [3:0] v, input logic [15:0] ui,
                         input logic [2:0] cnt, input logic rdy);
        sw = v;
        expect_strobe(ui, cnt, rdy);
        press(1'b1, 1'b0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outs(input string name, input logic [15:0] ui,
                              input logic [2:0] cnt, input logic rdy);
        check({name, "_userInput"}, 32'(userInput), 32'(ui));
        check({name, "_digitCount"}, 32'(digitCount), 32'(cnt));
        check({name, "_inputReady"}, 32'(inputReady), 32'(rdy));
    endtask

    initial begin
        int s0;
        checks   = 0;
        fails    = 0;
        strobes  = 0;
        rst      = 1'b1;
        enable   = 1'b1;
        sw       = 4'h0;
        btnEnter = 1'b0;
        btnDel   = 1'b0;

        #50;
        check_outs("reset", 16'h0000, 3'd0, 1'b0);
        check("reset_digitStrobe", 32'(digitStrobe), 32'(0));
        #80;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: four digits fill the guess
        s0 = strobes;
        digit(4'hF, 16'h000F, 3'd1, 1'b0);
        digit(4'hF, 16'h00FF, 3'd2, 1'b0);
        digit(4'h1, 16'h0FF1, 3'd3, 1'b0);
        digit(4'h2, 16'hFF12, 3'd4, 1'b1);
        check_outs("t1", 16'hFF12, 3'd4, 1'b1);
        check("t1_strobes", 32'(strobes - s0), 32'(4));

        // 2: bouncing input, then a steady press
        reset_dut();
        sw = 4'h7;
        expect_strobe(16'h0007, 3'd1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            btnEnter = ~btnEnter;
            repeat (2) @(negedge clk);
        end
        btnEnter = 1'b1;
        repeat (10) @(negedge clk);
        btnEnter = 1'b0;
        repeat (10) @(negedge clk);
        check_outs("t2", 16'h0007, 3'd1, 1'b0);

        // 3: delete in ENTER and from DONE
        reset_dut();
        digit(4'hA, 16'h000A, 3'd1, 1'b0);
        digit(4'hB, 16'h00AB, 3'd2, 1'b0);
        expect_strobe(16'h000A, 3'd1, 1'b0);
        press(1'b0, 1'b1);
        check_outs("t3a", 16'h000A, 3'd1, 1'b0);
        expect_strobe(16'h0000, 3'd0, 1'b0);
        press(1'b0, 1'b1);
        digit(4'hF, 16'h000F, 3'd1, 1'b0);
        digit(4'hF, 16'h00FF, 3'd2, 1'b0);
        digit(4'h1, 16'h0FF1, 3'd3, 1'b0);
        digit(4'h2, 16'hFF12, 3'd4, 1'b1);
        expect_strobe(16'h0FF1, 3'd3, 1'b0);
        press(1'b0, 1'b1);
        check_outs("t3b", 16'h0FF1, 3'd3, 1'b0);

        // 4: Enter ignored in DONE; simultaneous Enter+Del ignored
        digit(4'h2, 16'hFF12, 3'd4, 1'b1);
        s0 = strobes;
        sw = 4'h3;
        press(1'b1, 1'b0);
        check_outs("t4a", 16'hFF12, 3'd4, 1'b1);
        check("t4a_strobes", 32'(strobes - s0), 32'(0));
        expect_strobe(16'h0FF1, 3'd3, 1'b0);
        press(1'b0, 1'b1);
        s0 = strobes;
        press(1'b1, 1'b1);
        check_outs("t4b", 16'h0FF1, 3'd3, 1'b0);
        check("t4b_strobes", 32'(strobes - s0), 32'(0));

        // 5: disable clears; presses while disabled are dropped
        reset_dut();
        digit(4'h1, 16'h0001, 3'd1, 1'b0);
        digit(4'h2, 16'h0012, 3'd2, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check_outs("t5_disable", 16'h0000, 3'd0, 1'b0);
        s0 = strobes;
        sw = 4'h9;
        press(1'b1, 1'b0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_outs("t5_dropped", 16'h0000, 3'd0, 1'b0);
        check("t5_strobes", 32'(strobes - s0), 32'(0));
        digit(4'h5, 16'h0005, 3'd1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_outs("t5_async_rst", 16'h0000, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 6: delete with nothing held
        s0 = strobes;
        press(1'b0, 1'b1);
        check_outs("t6", 16'h0000, 3'd0, 1'b0);
        check("t6_strobes", 32'(strobes - s0), 32'(0));

        repeat (4) @(negedge clk);
        check("pending_strobes", 32'(q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
